// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI command arbiter: FSM state encoding,
// default bus widths and the rotating round-robin pick.
package spi_arb_pkg;

  localparam int SPI_ARB_ADDR_W = 7;
  localparam int SPI_ARB_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } arb_state_t;

  // Index of the first set bit of valid, scanning upward from ptr+1 with wrap
  // over n requesters. Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic int rr_pick(input logic [7:0] valid, input int ptr, input int n);
    int idx;
    int pick;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (ptr + k) % n;
      if (k <= n && !found && valid[idx[2:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin pick: first valid requester after ptr, with wrap.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [7:0] valid_ext;
  int         pick;

  always_comb begin
    valid_ext = 8'(req_valid);
    pick      = rr_pick(valid_ext, int'(ptr), N_REQ);
  end

  assign grant_idx = PTR_W'(pick);
  assign grant_any = |req_valid;

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI command engine between N_REQ requesters,
// one command in flight. Define SPI_ARB_TIMEOUT_EN to enable the engine-hang watchdog.
//
//   state   | meaning
//   S_IDLE  | no command; arbitrate and latch the winner
//   S_ISSUE | drive cmd_* to the engine until matching ack (or watchdog abort)
//   S_GAP   | one idle cycle between commands, busy released
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int ADDR_W      = SPI_ARB_ADDR_W,
  parameter int DATA_W      = SPI_ARB_DATA_W,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_wr,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_done,
  output logic                     req_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy,
  output logic                     error,
  output logic                     cmd_read,
  output logic                     cmd_write,
  input  logic                     cmd_read_ack,
  input  logic                     cmd_write_ack,
  output logic [ADDR_W-1:0]        read_addr,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  input  logic [DATA_W-1:0]        read_data
);

  localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("spi_cmd_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cmd_rd_q, cmd_rd_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                ack_hit;
`ifdef SPI_ARB_TIMEOUT_EN
  logic                err_q, err_d;
  logic                error_q, error_d;
  logic [31:0]         cnt_q, cnt_d;
`endif

  spi_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cmd_rd_d = cmd_rd_q;
    cmd_wr_d = cmd_wr_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d    = 1'b0;
    error_d  = error_q;
    cnt_d    = cnt_q;
`endif
    // An ack only counts once the matching command is actually on the wire.
    ack_hit  = (cmd_wr_q & cmd_write_ack) | (cmd_rd_q & cmd_read_ack);

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          wr_d    = req_wr[grant_idx];
          addr_d  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
          ptr_d   = grant_idx;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (ack_hit) begin
          cmd_rd_d = 1'b0;
          cmd_wr_d = 1'b0;
          done_d   = N_REQ'(1) << ptr_q;
          if (!wr_q) rdata_d = read_data;
          state_d  = S_GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYC)) begin
          cmd_rd_d = 1'b0;
          cmd_wr_d = 1'b0;
          done_d   = N_REQ'(1) << ptr_q;
          err_d    = 1'b1;
          rdata_d  = '0;
          error_d  = 1'b1;
          state_d  = S_GAP;
        end
`endif
        else begin
          cmd_wr_d = wr_q;
          cmd_rd_d = ~wr_q;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d    = cnt_q + 32'd1;
`endif
        end
      end
      S_GAP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_W'(N_REQ - 1);
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q    <= err_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req_done   = done_q;
  assign rsp_rdata  = rdata_q;
  assign busy       = busy_q;
  assign cmd_read   = cmd_rd_q;
  assign cmd_write  = cmd_wr_q;
  assign read_addr  = addr_q;
  assign write_addr = addr_q;
  assign write_data = wdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign req_err    = err_q;
  assign error      = error_q;
`else
  assign req_err    = 1'b0;
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter: transaction-level reference model,
// simple engine responder, directed scenarios plus a randomized traffic phase.
module tb_spi_cmd_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int TO     = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_wr = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata = '0;
  logic [N_REQ-1:0]        req_done;
  logic                    req_err;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    busy, error, cmd_read, cmd_write;
  logic                    cmd_read_ack = 1'b0, cmd_write_ack = 1'b0;
  logic [ADDR_W-1:0]       read_addr, write_addr;
  logic [DATA_W-1:0]       write_data;
  logic [DATA_W-1:0]       read_data = '0;

  spi_cmd_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .req_err(req_err), .rsp_rdata(rsp_rdata), .busy(busy), .error(error),
    .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_read_ack(cmd_read_ack),
    .cmd_write_ack(cmd_write_ack), .read_addr(read_addr), .write_addr(write_addr),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- engine responder ----------------
  int         eng_delay = 1;
  bit         eng_hang = 1'b0, eng_stray = 1'b0, eng_rand = 1'b0, eng_noise = 1'b0, eng_fixed = 1'b0;
  logic [7:0] eng_val = 8'h00;
  int         e_cnt = 0;
  int         rnd_delay = 1;
  int         wr_seen = 0;

  always @(negedge clk) begin
    cmd_write_ack = 1'b0;
    cmd_read_ack  = 1'b0;
    if (!eng_fixed) read_data = 8'($urandom);
    if (cmd_write) wr_seen++;
    if (cmd_write || cmd_read) begin
      e_cnt++;
      if (!eng_hang && e_cnt >= (eng_rand ? rnd_delay : eng_delay)) begin
        if (cmd_write) cmd_write_ack = 1'b1;
        else begin
          cmd_read_ack = 1'b1;
          if (eng_fixed) read_data = eng_val;
        end
        e_cnt = 0;
      end else if (eng_stray && cmd_write && e_cnt == 2) begin
        cmd_read_ack = 1'b1;
      end
    end else begin
      e_cnt     = 0;
      rnd_delay = $urandom_range(1, 6);
      if (eng_noise) begin
        cmd_write_ack = ($urandom_range(0, 7) == 0);
        cmd_read_ack  = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks one outstanding transaction: who owns the engine, how long its
  // command has been on the wire, and what completion is due this cycle.
  function automatic int rr_winner(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  int                m_owner = -1, m_last = N_REQ - 1, m_age = 0, m_w = -1;
  bit                m_gap = 0, m_cmd = 0, m_wr = 0, m_busy = 0, m_sticky = 0, m_rerr = 0, m_ok = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0, m_rdata = '0;
  logic [N_REQ-1:0]  m_done = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_last = N_REQ - 1; m_age = 0; m_gap = 0; m_cmd = 0;
      m_busy = 0; m_sticky = 0; m_rerr = 0; m_rdata = '0; m_done = '0;
      m_addr = '0; m_data = '0; m_ok = 1;
    end else begin
      m_done = '0;
      m_rerr = 0;
      if (m_gap) begin
        m_gap  = 0;
        m_busy = 0;
      end else if (m_owner < 0) begin
        m_w = rr_winner(req_valid, m_last);
        if (m_w >= 0) begin
          m_owner = m_w; m_last = m_w;
          m_wr    = req_wr[m_w];
          m_addr  = req_addr[m_w*ADDR_W +: ADDR_W];
          m_data  = req_wdata[m_w*DATA_W +: DATA_W];
          m_busy  = 1; m_cmd = 0; m_age = 0;
        end
      end else if (m_cmd && (m_wr ? cmd_write_ack : cmd_read_ack)) begin
        m_done = N_REQ'(1) << m_owner;
        if (!m_wr) m_rdata = read_data;
        m_cmd = 0; m_owner = -1; m_gap = 1;
      end else if (TO_EN && m_age == TO) begin
        m_done = N_REQ'(1) << m_owner;
        m_rerr = 1; m_sticky = 1; m_rdata = '0;
        m_cmd = 0; m_owner = -1; m_gap = 1;
      end else begin
        m_cmd = 1;
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmd_write", 32'(cmd_write), 32'(m_cmd && m_wr));
      chk("cmd_read", 32'(cmd_read), 32'(m_cmd && !m_wr));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("req_done", 32'(req_done), 32'(m_done));
      chk("req_err", 32'(req_err), 32'(m_rerr));
      chk("error", 32'(error), 32'(m_sticky));
      if (m_cmd) begin
        chk("cmd_addr", 32'(m_wr ? write_addr : read_addr), 32'(m_addr));
        if (m_wr) chk("write_data", 32'(write_data), 32'(m_data));
      end
      if (m_done != '0 && (!m_wr || m_rerr)) chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic post(input int i, input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_wr[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_cmd(input string nm, output int at);
    at = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cmd_write || cmd_read) begin
        at = cyc;
        return;
      end
    end
    chk({nm, "_cmd_bound"}, 32'(cmd_write | cmd_read), 1);
  endtask

  task automatic wait_done(input string nm, input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (req_done != '0) begin
        at = cyc;
        return;
      end
    end
    chk({nm, "_done_bound"}, 32'(|req_done), 1);
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) if (req_done[i]) req_valid[i] = 1'b0;
      if (req_valid == '0 && !busy) return;
    end
    chk({nm, "_drain"}, 32'(busy), 0);
  endtask

  function automatic int oh_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int t0, tc, td, nd, low_run, min_low, dcount;
  bit seen;
  int order[9];
  int wr_before;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'({cmd_write, cmd_read}), 0);
    chk("rst_busy_err", 32'({busy, error, req_err}), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 single write, engine acks after 5 clk
    eng_delay = 5;
    post(0, 1'b1, 7'h12, 8'hA5);
    t0 = cyc;
    wait_cmd("t1", tc);
    chk("t1_latency", 32'(tc - t0), 2);
    chk("t1_cmd_write", 32'(cmd_write), 1);
    chk("t1_write_addr", 32'(write_addr), 32'h12);
    chk("t1_write_data", 32'(write_data), 32'hA5);
    wait_done("t1", 50, td);
    chk("t1_done", 32'(req_done), 32'b001);
    chk("t1_err", 32'(req_err), 0);
    chk("t1_cmd_to_done", 32'(td - tc), 5);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);

    // T2 read from requester 2
    eng_fixed = 1'b1; eng_val = 8'h3C; eng_delay = 3;
    wr_before = wr_seen;
    post(2, 1'b0, 7'h7E, 8'h00);
    wait_cmd("t2", tc);
    chk("t2_read_addr", 32'(read_addr), 32'h7E);
    wait_done("t2", 50, td);
    chk("t2_done", 32'(req_done), 32'b100);
    chk("t2_rdata", 32'(rsp_rdata), 32'h3C);
    chk("t2_no_write", 32'(wr_seen - wr_before), 0);
    req_valid[2] = 1'b0;
    eng_fixed = 1'b0;
    repeat (3) @(negedge clk);

    // T3 round robin with all three continuously valid
    eng_rand = 1'b1;
    for (int i = 0; i < N_REQ; i++) post(i, 1'($urandom), 7'($urandom), 8'($urandom));
    nd = 0; low_run = 0; min_low = 1000; seen = 0;
    for (int c = 0; c < 400 && nd < 9; c++) begin
      @(negedge clk);
      if (cmd_write || cmd_read) begin
        if (seen && low_run > 0 && low_run < min_low) min_low = low_run;
        seen = 1; low_run = 0;
      end else low_run++;
      if (req_done != '0) begin
        order[nd] = oh_idx(req_done);
        nd++;
        if (nd == 9) req_valid = '0;
      end
    end
    chk("t3_count", 32'(nd), 9);
    for (int k = 0; k < 9; k++) chk($sformatf("t3_order%0d", k), 32'(order[k]), 32'(k % 3));
    chk("t3_min_gap_ge2", 32'(min_low >= 2), 1);
    drain("t3");

    // T4 stray read ack during a write, requester withdraws after grant
    eng_rand = 1'b0; eng_delay = 6; eng_stray = 1'b1;
    post(0, 1'b1, 7'h55, 8'h0F);
    wait_cmd("t4", tc);
    req_valid[0] = 1'b0;
    dcount = 0; td = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_done != '0) begin
        dcount++;
        if (td < 0) td = cyc;
        chk("t4_done", 32'(req_done), 32'b001);
      end
    end
    chk("t4_done_once", 32'(dcount), 1);
    chk("t4_cmd_to_done", 32'(td - tc), 6);
    eng_stray = 1'b0;

    // randomized traffic with noisy acks while idle
    eng_rand = 1'b1; eng_noise = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (req_done[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0)
          post(i, 1'($urandom), 7'($urandom), 8'($urandom));
      end
    end
    drain("rand");
    eng_noise = 1'b0; eng_rand = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // T5 watchdog: engine never acks
    eng_hang = 1'b1;
    post(1, 1'b1, 7'h21, 8'h99);
    wait_cmd("t5", tc);
    wait_done("t5", 60, td);
    chk("t5_cmd_to_abort", 32'(td - tc), TO);
    chk("t5_done", 32'(req_done), 32'b010);
    chk("t5_req_err", 32'(req_err), 1);
    chk("t5_rdata_zero", 32'(rsp_rdata), 0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_error_set", 32'(error), 1);
    eng_hang = 1'b0; eng_delay = 2;
    post(1, 1'b1, 7'h22, 8'h11);
    wait_done("t5b", 50, td);
    chk("t5b_req_err", 32'(req_err), 0);
    chk("t5b_error_sticky", 32'(error), 1);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
`endif

    // T6 reset mid-command
    eng_hang = 1'b1;
    post(1, 1'b1, 7'h33, 8'h44);
    wait_cmd("t6", tc);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_cmd", 32'({cmd_write, cmd_read}), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_error", 32'(error), 0);
    chk("t6_done", 32'(req_done), 0);
    rst_n = 1'b1;
    eng_hang = 1'b0; eng_delay = 3;
    post(0, 1'b0, 7'h01, 8'h00);
    post(2, 1'b1, 7'h02, 8'h5A);
    wait_done("t6", 50, td);
    chk("t6_first_after_reset", 32'(req_done), 32'b001);
    for (int i = 0; i < N_REQ; i++) if (req_done[i]) req_valid[i] = 1'b0;
    drain("t6");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
